constraint_sampler: RTL

//  Generator side of the constraint-check flow: emits pseudo-random candidate assignments for one

---
 rtl/constraint_sampler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/constraint_sampler.sv
// rtl/constraint_sampler.sv - LFSR candidate generator with OR-mask rejection loop and valid/ready output
module constraint_sampler #(
  parameter int                WIDTH     = 25,
  parameter logic [WIDTH-1:0]  OR_MASK   = 25'h3c0e8c,
  parameter logic [31:0]       SEED      = 32'h1,
  parameter int                MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
  input  logic [WIDTH-1:0] bias,
  input  logic             start,
  input  logic [15:0]      num_samples,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [15:0]      total_rejects
);

  localparam logic [31:0] TAPS       = 32'h80200003;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] TRIES_LAST = 16'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [15:0] remaining;
  logic [15:0] tries;

  logic [31:0]      lfsr_next;
  logic [31:0]      seed_fixed;
  logic [WIDTH-1:0] cand;
  logic             cand_ok;

  // Candidate built from the current LFSR value, plus the Galois step and seed sanitising.
  always_comb begin
    lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    seed_fixed = (seed_val == 32'h0) ? 32'h1 : seed_val;
    cand       = lfsr[WIDTH-1:0] ^ bias;
    cand_ok    = |(cand | OR_MASK);
  end

  // Batch controller: the LFSR only moves in GEN, so a stalled HOLD freezes the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lfsr          <= SEED_EFF;
      remaining     <= 16'h0;
      tries         <= 16'h0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      total_rejects <= 16'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FAIL: begin
          // Seed load lands on the same edge as start, so GEN sees the new seed.
          if (seed_load) begin
            lfsr <= seed_fixed;
          end
          if (start) begin
            fail <= 1'b0;
            if (num_samples == 16'h0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              remaining     <= num_samples;
              total_rejects <= 16'h0;
              tries         <= 16'h0;
              busy          <= 1'b1;
              state         <= S_GEN;
            end
          end
        end
        S_GEN: begin
          lfsr <= lfsr_next;
          if (cand_ok) begin
            out_data  <= cand;
            out_valid <= 1'b1;
            tries     <= 16'h0;
            state     <= S_HOLD;
          end else begin
            if (total_rejects != 16'hFFFF) begin
              total_rejects <= total_rejects + 16'h1;
            end
            tries <= tries + 16'h1;
            if (tries == TRIES_LAST) begin
              fail      <= 1'b1;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              state     <= S_FAIL;
            end
          end
        end
        S_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (remaining == 16'h1) begin
              remaining <= 16'h0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              remaining <= remaining - 16'h1;
              state     <= S_GEN;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
